// File: rtl/apb_usrt_param.sv
// apb_usrt_param: APB slave driving a synchronous serial port (uClk/uTx/uRx) with TX and RX FIFOs.
// Define USRT_PARITY_EN to add an even-parity bit to every frame in both directions.
`timescale 1ns/1ps

module usrtFifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wData,
  output logic [W-1:0] rData,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wrPtr, rdPtr;
  logic         doPush, doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop & ~empty;
  // A pop in the same cycle frees the slot this push lands in.
  assign doPush = push & (~full | doPop);
  assign rData  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wData;
  end
endmodule

module apb_usrt_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 40
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSelect,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [31:0]       pAddress,
  input  logic [DATA_W-1:0] pWData,
  output logic [DATA_W-1:0] pRData,
  output logic              pReady,
  output logic              uClk,
  output logic              uTx,
  input  logic              uRx
);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef USRT_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } txState_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_DATA,
`ifdef USRT_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rxState_t;

  txState_t          txState, txNext;
  rxState_t          rxState, rxNext;
  logic [CW-1:0]     divCnt;
  logic              divWrap, riseTick, fallTick;
  logic [1:0]        regSel, ctrl;
  logic              access, txStall, txPush, rxPop, statusRd, ctrlWr;
  logic              txFull, txEmpty, rxFull, rxEmpty, txPop, txGo, txBusy;
  logic              rxPush, rxOvf, rxParOk, ovr, perr;
  logic [DATA_W-1:0] txHead, rxHead, txShift, rxShift, rdMux;
  logic [BW-1:0]     txBitCnt, rxBitCnt;
  logic [6:0]        status;
  logic              unusedAddr;

  assign unusedAddr = ^{pAddress[31:4], pAddress[1:0]};

  // uClk divider; ticks mark the pClk cycle whose edge moves uClk.
  assign divWrap  = (divCnt == CW'(DIV - 1));
  assign riseTick = divWrap & ~uClk;
  assign fallTick = divWrap & uClk;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      divCnt <= '0;
      uClk   <= 1'b0;
    end else if (divWrap) begin
      divCnt <= '0;
      uClk   <= ~uClk;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  assign regSel   = pAddress[3:2];
  assign access   = pSelect & pEnable;
  assign txStall  = access & pWrite & (regSel == 2'd0) & txFull & ~txPop;
  assign pReady   = pReset & access & ~txStall;
  assign txPush   = pReady & pWrite & (regSel == 2'd0);
  assign rxPop    = pReady & ~pWrite & (regSel == 2'd0);
  assign statusRd = pReady & ~pWrite & (regSel == 2'd1);
  assign ctrlWr   = pReady & pWrite & (regSel == 2'd2);
  assign status   = {txBusy, perr, ovr, rxEmpty, rxFull, txEmpty, txFull};

  always_comb begin
    rdMux = '0;
    case (regSel)
      2'd0:    if (!rxEmpty) rdMux = rxHead;
      2'd1:    rdMux = DATA_W'(status);
      2'd2:    rdMux = DATA_W'(ctrl);
      default: rdMux = '0;
    endcase
  end

  assign pRData = (pReady & ~pWrite) ? rdMux : '0;

  usrtFifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) txFifo (
    .clk(pClk), .rstN(pReset), .push(txPush), .pop(txPop), .wData(pWData),
    .rData(txHead), .full(txFull), .empty(txEmpty));

  usrtFifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clk(pClk), .rstN(pReset), .push(rxPush), .pop(rxPop), .wData(rxShift),
    .rData(rxHead), .full(rxFull), .empty(rxEmpty));

  assign rxOvf = rxPush & rxFull & ~rxPop;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      ctrl <= 2'b11;
      ovr  <= 1'b0;
    end else begin
      if (ctrlWr) ctrl <= pWData[1:0];
      if (rxOvf) ovr <= 1'b1;
      else if (statusRd) ovr <= 1'b0;
    end
  end

  // TX: state names the bit currently on the line; every transition happens on fallTick.
  assign txGo   = ctrl[0] & ~txEmpty;
  assign txPop  = fallTick & txGo & ((txState == TX_IDLE) || (txState == TX_STOP));
  assign txBusy = (txState != TX_IDLE);

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) txState <= TX_IDLE;
    else         txState <= txNext;
  end

  always_comb begin
    txNext = txState;
    if (fallTick) begin
      case (txState)
        TX_IDLE:   if (txGo) txNext = TX_START;
        TX_START:  txNext = TX_DATA;
`ifdef USRT_PARITY_EN
        TX_DATA:   if (txBitCnt == BW'(DATA_W - 1)) txNext = TX_PARITY;
        TX_PARITY: txNext = TX_STOP;
`else
        TX_DATA:   if (txBitCnt == BW'(DATA_W - 1)) txNext = TX_STOP;
`endif
        TX_STOP:   txNext = txGo ? TX_START : TX_IDLE;
        default:   txNext = TX_IDLE;
      endcase
    end
  end

`ifdef USRT_PARITY_EN
  logic txPar;
`endif

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      txShift  <= '0;
      txBitCnt <= '0;
`ifdef USRT_PARITY_EN
      txPar    <= 1'b0;
`endif
    end else if (fallTick) begin
      if (txPop) begin
        txShift <= txHead;
`ifdef USRT_PARITY_EN
        txPar   <= ^txHead;
`endif
      end else if (txState == TX_DATA) begin
        txShift  <= txShift >> 1;
        txBitCnt <= txBitCnt + 1'b1;
      end
      if (txState == TX_START) txBitCnt <= '0;
    end
  end

  always_comb begin
    uTx = 1'b1;
    case (txState)
      TX_START:  uTx = 1'b0;
      TX_DATA:   uTx = txShift[0];
`ifdef USRT_PARITY_EN
      TX_PARITY: uTx = txPar;
`endif
      default:   uTx = 1'b1;
    endcase
  end

  // RX: uRx is sampled only on riseTick.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) rxState <= RX_IDLE;
    else         rxState <= rxNext;
  end

  always_comb begin
    rxNext = rxState;
    if (riseTick) begin
      case (rxState)
        RX_IDLE:   if (!uRx && ctrl[1]) rxNext = RX_DATA;
`ifdef USRT_PARITY_EN
        RX_DATA:   if (rxBitCnt == BW'(DATA_W - 1)) rxNext = RX_PARITY;
        RX_PARITY: rxNext = RX_STOP;
`else
        RX_DATA:   if (rxBitCnt == BW'(DATA_W - 1)) rxNext = RX_STOP;
`endif
        default:   rxNext = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxShift  <= '0;
      rxBitCnt <= '0;
    end else if (riseTick) begin
      if (rxState == RX_IDLE) rxBitCnt <= '0;
      if (rxState == RX_DATA) begin
        rxShift  <= {uRx, rxShift[DATA_W-1:1]};
        rxBitCnt <= rxBitCnt + 1'b1;
      end
    end
  end

`ifdef USRT_PARITY_EN
  logic rxParBad, perrSet;
  assign perrSet = riseTick & (rxState == RX_PARITY) & (uRx ^ (^rxShift));
  assign rxParOk = ~rxParBad;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxParBad <= 1'b0;
      perr     <= 1'b0;
    end else begin
      if (riseTick && rxState == RX_PARITY) rxParBad <= uRx ^ (^rxShift);
      if (perrSet) perr <= 1'b1;
      else if (statusRd) perr <= 1'b0;
    end
  end
`else
  assign rxParOk = 1'b1;
  assign perr    = 1'b0;
`endif

  // A zero stop bit or a parity mismatch silently drops the frame.
  always_comb begin
    rxPush = 1'b0;
    if (riseTick && rxState == RX_STOP) rxPush = uRx & rxParOk;
  end
endmodule

// File: tb/tb_apb_usrt_param.sv
// tb_apb_usrt_param: randomized APB/serial stimulus with a queue-based reference model and scoreboard monitors.
`timescale 1ns/1ps

module tb_apb_usrt_param;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DV    = 40;
`ifdef USRT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          pClk = 1'b0, pReset = 1'b0;
  logic          pSelect = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
  logic [31:0]   pAddress = '0;
  logic [DW-1:0] pWData = '0;
  logic [DW-1:0] pRData;
  logic          pReady, uClk, uTx;
  logic          uRx = 1'b1;

  always #5 pClk = ~pClk;

  apb_usrt_param #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV(DV)) dut (
    .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable), .pWrite(pWrite),
    .pAddress(pAddress), .pWData(pWData), .pRData(pRData), .pReady(pReady),
    .uClk(uClk), .uTx(uTx), .uRx(uRx));

  int tests = 0, fails = 0;
  int rxQ[$], txExp[$], expRd[$];
  bit mOvr = 0, mPerr = 0;
  logic [1:0] mCtrl = 2'b11;
  int mTxCnt = 0;
  bit monActive = 0;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int expStatus();
    int s = 0;
    if (mTxCnt == DEPTH)        s += 1;
    if (mTxCnt == 0)            s += 2;
    if (rxQ.size() == DEPTH)    s += 4;
    if (rxQ.size() == 0)        s += 8;
    if (mOvr)                   s += 16;
    if (mPerr)                  s += 32;
    return s;
  endfunction

  // Read scoreboard: every completed APB read is compared against the oldest expectation.
  initial forever begin
    @(negedge pClk);
    if (pSelect && pEnable && pReady && !pWrite) begin
      if (expRd.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", pRData);
      end else begin
        check("rd_data", int'(pRData), expRd.pop_front());
      end
    end
  end

  // TX monitor: decodes frames on uTx at uClk rising edges, scores them against written words.
  initial begin
    int monCnt;
    logic [DW+PB:0] monBits;
    int w;
    monCnt = 0;
    monBits = '0;
    forever begin
      @(posedge uClk or negedge pReset);
      if (!pReset) begin
        monActive = 0;
      end else if (!monActive) begin
        if (uTx == 1'b0) begin
          monActive = 1;
          monCnt = 0;
          monBits = '0;
        end
      end else begin
        monBits[monCnt] = uTx;
        monCnt++;
        if (monCnt == DW + PB + 1) begin
          monActive = 0;
          w = int'(monBits[DW-1:0]);
          if (txExp.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_unexpected: got frame 0x%0h, expected none", w);
          end else begin
            check("tx_data", w, txExp.pop_front());
          end
`ifdef USRT_PARITY_EN
          check("tx_parity", int'(monBits[DW]), int'(^monBits[DW-1:0]));
`endif
          check("tx_stop", int'(monBits[DW+PB]), 1);
        end
      end
    end
  end

  task automatic waitUclkEdge(input logic lvl);
    logic prev;
    prev = uClk;
    for (int i = 0; i < 4 * DV; i++) begin
      @(posedge pClk); #1;
      if (uClk !== prev && uClk === lvl) return;
      prev = uClk;
    end
    tests++; fails++;
    $display("FAIL uclk_edge: got no edge in %0d cycles, expected one", 4 * DV);
  endtask

  task automatic apbXfer(input int addr, input bit wr, input int data, input int maxWait, output bit done);
    @(posedge pClk); #1;
    pSelect = 1; pEnable = 0; pWrite = wr; pAddress = addr; pWData = data[DW-1:0];
    @(posedge pClk); #1;
    pEnable = 1;
    done = 0;
    for (int i = 0; i <= maxWait; i++) begin
      @(negedge pClk);
      if (pReady) begin
        done = 1;
        break;
      end
    end
    @(posedge pClk); #1;
    pSelect = 0; pEnable = 0; pWrite = 0;
  endtask

  task automatic apbWrite(input int addr, input int data, input int maxWait);
    bit done;
    apbXfer(addr, 1'b1, data, maxWait, done);
    check("wr_done", int'(done), 1);
    if (done && addr == 0) begin
      txExp.push_back(data & 'hFF);
      if (!mCtrl[0]) mTxCnt++;
    end
    if (done && addr == 8) mCtrl = data[1:0];
  endtask

  task automatic apbRead(input int addr, input int exp);
    bit done;
    expRd.push_back(exp);
    apbXfer(addr, 1'b0, 0, 4, done);
    check("rd_ready", int'(done), 1);
  endtask

  task automatic readStatus();
    apbRead(4, expStatus());
    mOvr = 0;
    mPerr = 0;
  endtask

  task automatic readData();
    apbRead(0, (rxQ.size() != 0) ? rxQ.pop_front() : 0);
  endtask

  // kind: 0 good frame, 1 zero stop bit, 2 wrong parity bit.
  task automatic sendRx(input int word, input int kind, input bit popAtStop);
    waitUclkEdge(1'b0);
    uRx = 1'b0;
    for (int i = 0; i < DW; i++) begin
      waitUclkEdge(1'b0);
      uRx = word[i];
    end
`ifdef USRT_PARITY_EN
    waitUclkEdge(1'b0);
    uRx = (^word[DW-1:0]) ^ (kind == 2);
`endif
    waitUclkEdge(1'b0);
    uRx = (kind != 1);
    if (popAtStop) begin
      // Access phase lands in the cycle whose edge samples the stop bit.
      repeat (DV - 3) @(posedge pClk);
      readData();
    end else begin
      waitUclkEdge(1'b1);
    end
    if (mCtrl[1]) begin
      if (kind == 0) begin
        if (rxQ.size() < DEPTH) rxQ.push_back(word & 'hFF);
        else mOvr = 1;
      end else if (kind == 2) begin
        mPerr = 1;
      end
    end
    waitUclkEdge(1'b0);
    uRx = 1'b1;
  endtask

  task automatic waitTxDone();
    for (int i = 0; i < 20000 && txExp.size() != 0; i++) @(posedge pClk);
    check("tx_drain", txExp.size(), 0);
    waitUclkEdge(1'b0);
    repeat (2) @(posedge pClk);
  endtask

  initial begin
    bit done;
    time t0;
    int w;

    // Reset: outputs forced regardless of bus activity.
    pSelect = 1; pEnable = 1; pAddress = 4;
    repeat (5) @(posedge pClk); #1;
    check("rst_pready", int'(pReady), 0);
    check("rst_prdata", int'(pRData), 0);
    check("rst_utx", int'(uTx), 1);
    check("rst_uclk", int'(uClk), 0);
    pSelect = 0; pEnable = 0; pAddress = 0;
    @(negedge pClk);
    pReset = 1;

    waitUclkEdge(1'b1);
    t0 = $time;
    waitUclkEdge(1'b1);
    check("uclk_period", int'(($time - t0) / 10), 2 * DV);

    readStatus();
    apbRead(8, 3);
    apbWrite(12, 'hFF, 2);
    apbRead(12, 0);

    // Single frame, then a random burst that overruns the FIFO and stalls the bus.
    apbWrite(0, 'hFC, 2);
    waitTxDone();
    readStatus();
    for (int i = 0; i < 6; i++) apbWrite(0, int'($urandom_range(0, 255)), 3000);
    waitTxDone();
    readStatus();

    // Flow control with TX disabled.
    apbWrite(8, 2, 2);
    for (int i = 0; i < DEPTH; i++) apbWrite(0, int'($urandom_range(0, 255)), 2);
    readStatus();
    w = int'($urandom_range(0, 255));
    apbXfer(0, 1'b1, w, 10, done);
    check("txfull_stall", int'(done), 0);
    apbWrite(8, 3, 2);
    apbWrite(0, w, 4 * DV);
    waitTxDone();
    mTxCnt = 0;
    readStatus();

    // Single RX frame and empty read.
    sendRx('hA5, 0, 0);
    readStatus();
    readData();
    readStatus();
    readData();

    // Overflow, then a pop colliding with a push on a full FIFO.
    for (int i = 0; i < DEPTH + 1; i++) sendRx(int'($urandom_range(0, 255)), 0, 0);
    readStatus();
    readStatus();
    sendRx(int'($urandom_range(0, 255)), 0, 1);
    readStatus();
    for (int i = 0; i < DEPTH; i++) readData();
    readStatus();

    // Random mix of good and framing-error frames with random reads.
    for (int i = 0; i < 6; i++) begin
      sendRx(int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 1 : 0, 0);
      if ($urandom_range(0, 1) == 1) readData();
    end
    while (rxQ.size() != 0) readData();
    readStatus();

`ifdef USRT_PARITY_EN
    sendRx(int'($urandom_range(0, 255)), 2, 0);
    readStatus();
    readStatus();
`endif

    // RX disabled: frame ignored.
    apbWrite(8, 1, 2);
    sendRx(int'($urandom_range(0, 255)), 0, 0);
    readStatus();
    apbRead(8, 1);
    apbWrite(8, 3, 2);

    // Reset in the middle of a TX frame.
    apbWrite(0, int'($urandom_range(0, 255)), 2);
    for (int i = 0; i < 8 * DV && !monActive; i++) @(posedge pClk);
    check("tx_started", int'(monActive), 1);
    repeat (3) waitUclkEdge(1'b1);
    pReset = 0;
    #1;
    check("midrst_utx", int'(uTx), 1);
    check("midrst_uclk", int'(uClk), 0);
    txExp.delete();
    rxQ.delete();
    mOvr = 0; mPerr = 0; mCtrl = 2'b11; mTxCnt = 0;
    repeat (4) @(posedge pClk);
    @(negedge pClk);
    pReset = 1;
    readStatus();
    apbRead(8, 3);
    sendRx(int'($urandom_range(0, 255)), 0, 0);
    readData();
    apbWrite(0, int'($urandom_range(0, 255)), 2);
    waitTxDone();
    readStatus();

    repeat (5) @(posedge pClk);
    check("rd_queue_drained", expRd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
